// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int CNT_W_DEF  = 16;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_REQ  = 3'd1;
   localparam state_t S_WAIT = 3'd2;
   localparam state_t S_HOLD = 3'd3;
   localparam state_t S_RDR1 = 3'd4;
   localparam state_t S_RDR2 = 3'd5;

endpackage

// File: rtl/fetch_ir_buf.sv
// One-entry holding register for the fetched instruction.
// Squash beats load, load beats accept.
module fetch_ir_buf
   import fetch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              squash,
   input  logic              accept,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] ir_out,
   output logic              ir_valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_out   <= '0;
         ir_valid <= 1'b0;
      end else if (squash) begin
         ir_valid <= 1'b0;
      end else if (load) begin
         ir_out   <= data;
         ir_valid <= 1'b1;
      end else if (accept) begin
         ir_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one memory read per instruction, PC increment/redirect
// pulses, and a valid/ready hand-off of the fetched word to decode.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_inc_en,
   output logic              pc_write_en,
   output logic [ADDR_W-1:0] pc_load_addr,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              halt,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [DATA_W-1:0] ir_out,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [CNT_W-1:0]  fetch_cnt,
   output logic              busy
);

   state_t state;
   state_t state_nxt;
   logic   drop_pend;
   logic   drop_nxt;
   logic   rsp_ok;
   logic   load;
   logic   accept;
   logic   issue;

   always_comb begin
      rsp_ok = (state == S_WAIT) && mem_rvalid && !drop_pend;
      load   = rsp_ok && !jump_req;
      accept = ir_valid && ir_ready && !jump_req;
      issue  = (state == S_REQ) && !jump_req;
      // a response arriving with the jump is simply dropped, nothing pends
      if (drop_pend)
         drop_nxt = !mem_rvalid;
      else
         drop_nxt = (state == S_WAIT) && jump_req && !mem_rvalid;
   end

   always_comb begin
      state_nxt = state;
      if (jump_req) begin
         state_nxt = S_RDR1;
      end else begin
         case (state)
            S_IDLE: if (!halt) state_nxt = S_REQ;
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: if (rsp_ok) state_nxt = S_HOLD;
            S_HOLD:
               if (accept)
                  state_nxt = halt ? S_IDLE : S_REQ;
            S_RDR1: state_nxt = S_RDR2;
            S_RDR2:
               if (!drop_pend)
                  state_nxt = halt ? S_IDLE : S_REQ;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         drop_pend    <= 1'b0;
         busy         <= 1'b0;
         pc_inc_en    <= 1'b0;
         pc_write_en  <= 1'b0;
         pc_load_addr <= '0;
         mem_rd_en    <= 1'b0;
         mem_addr     <= '0;
         fetch_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         drop_pend   <= drop_nxt;
         busy        <= (state_nxt != S_IDLE);
         pc_inc_en   <= load;
         pc_write_en <= jump_req;
         mem_rd_en   <= issue;
         if (jump_req)
            pc_load_addr <= jump_addr;
         if (issue)
            mem_addr <= pc_in;
         if (accept)
            fetch_cnt <= fetch_cnt + 1'b1;
      end
   end

   fetch_ir_buf #(
      .DATA_W (DATA_W)
   ) u_ir_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .squash   (jump_req),
      .accept   (accept),
      .data     (mem_rdata),
      .ir_out   (ir_out),
      .ir_valid (ir_valid)
   );

endmodule
